fp_lane_unpacker: RTL

//  Receives packed FP vector words tagged with an fp_format_e and serialises them into
//  per-lane unpacked elements, one lane per output beat: sign, unbiased exponent, mantissa, classmask.
//  It is the consumer/decoder side of the packed multi-format encoding in fpnew_pkg_versacore.

---
 rtl/fp_lane_unpacker_if.sv | 33 +++
 rtl/fp_lane_unpacker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_lane_unpacker_if.sv
// rtl/fp_lane_unpacker_if.sv - packed-word input and unpacked-element output handshakes
interface fp_lane_unpacker_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned EXP_W  = 10,
    parameter int unsigned MAN_W  = 24,
    parameter int unsigned LANE_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_word;
    logic [2:0]        in_fmt;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MAN_W-1:0]  out_man;
    logic [9:0]        out_class;
    logic [LANE_W-1:0] out_lane;
    logic              out_last;
    logic              fmt_err;

    modport slave (
        input  in_valid, in_word, in_fmt, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_man, out_class,
               out_lane, out_last, fmt_err
    );

    modport master (
        output in_valid, in_word, in_fmt, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_man, out_class,
               out_lane, out_last, fmt_err
    );
endinterface

// File: rtl/fp_lane_unpacker.sv
// rtl/fp_lane_unpacker.sv - serialises packed multi-format FP words into per-lane decoded elements
module fp_lane_unpacker #(
    parameter int unsigned Width     = 32,
    parameter logic [0:4]  FpFmtMask = 5'b10111
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fp_lane_unpacker_if.slave  bus
);
    // Format index order: FP32, FP64, FP16, FP8, FP16ALT
    function automatic int unsigned f_exp_bits(input int unsigned f);
        case (f)
            0: return 8;
            1: return 11;
            2: return 5;
            3: return 5;
            4: return 8;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned f_man_bits(input int unsigned f);
        case (f)
            0: return 23;
            1: return 52;
            2: return 10;
            3: return 2;
            4: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned f_width(input int unsigned f);
        return 1 + f_exp_bits(f) + f_man_bits(f);
    endfunction

    function automatic logic [7:0] f_sup();
        logic [7:0] v = '0;
        for (int unsigned f = 0; f < 5; f++)
            v[f] = FpFmtMask[f] && (f_width(f) <= Width);
        return v;
    endfunction

    localparam logic [7:0] FMT_SUP = f_sup();

    function automatic int unsigned f_super_exp();
        int unsigned m = 1;
        for (int unsigned f = 0; f < 5; f++)
            if (FMT_SUP[f] && f_exp_bits(f) > m) m = f_exp_bits(f);
        return m;
    endfunction

    function automatic int unsigned f_super_man();
        int unsigned m = 1;
        for (int unsigned f = 0; f < 5; f++)
            if (FMT_SUP[f] && f_man_bits(f) > m) m = f_man_bits(f);
        return m;
    endfunction

    function automatic int unsigned f_max_lanes();
        int unsigned m = 1;
        for (int unsigned f = 0; f < 5; f++)
            if (FMT_SUP[f] && Width / f_width(f) > m) m = Width / f_width(f);
        return m;
    endfunction

    localparam int unsigned EXP_W  = f_super_exp() + 2;
    localparam int unsigned MAN_W  = f_super_man() + 1;
    localparam int unsigned NL_MAX = f_max_lanes();
    localparam int unsigned LANE_W = (NL_MAX > 1) ? $clog2(NL_MAX) : 1;

    function automatic logic [8*LANE_W-1:0] f_last_lanes();
        logic [8*LANE_W-1:0] v = '0;
        for (int unsigned f = 0; f < 8; f++)
            if (FMT_SUP[f]) v[f*LANE_W +: LANE_W] = LANE_W'(Width / f_width(f) - 1);
        return v;
    endfunction

    localparam logic [8*LANE_W-1:0] LAST_LANES = f_last_lanes();

    localparam logic [9:0] C_NEGINF  = 10'h001, C_NEGNORM  = 10'h002, C_NEGSUB = 10'h004,
                           C_NEGZERO = 10'h008, C_POSZERO  = 10'h010, C_POSSUB = 10'h020,
                           C_POSNORM = 10'h040, C_POSINF   = 10'h080, C_SNAN   = 10'h100,
                           C_QNAN    = 10'h200;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic [9:0]       cls;
    } dec_t;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [Width-1:0]  word_q;
    logic [2:0]        fmt_q;
    logic [LANE_W-1:0] lane_q, last_lane_q;
    logic              fmt_err_q;
    logic              last, in_ready, accept, load;
    dec_t              dec [8];

    assign last   = (lane_q == last_lane_q);
    assign accept = bus.in_valid & in_ready;
    assign load   = accept & FMT_SUP[bus.in_fmt];

    // One decoder per enabled format, all looking at the current lane of the held word
    for (genvar f = 0; f < 8; f++) begin : g_fmt
        if (FMT_SUP[f]) begin : g_dec
            localparam int unsigned EB   = f_exp_bits(f);
            localparam int unsigned MB   = f_man_bits(f);
            localparam int unsigned FW   = 1 + EB + MB;
            localparam int unsigned BIAS = (1 << (EB - 1)) - 1;

            logic [FW-1:0] lb;
            logic [EB-1:0] e;
            logic [MB-1:0] fr;
            logic [MB:0]   man_raw;
            dec_t          d;

            assign lb = FW'(word_q >> (lane_q * FW));
            assign e  = lb[FW-2 -: EB];
            assign fr = lb[MB-1:0];

            always_comb begin
                d       = '0;
                man_raw = '0;
                d.sign  = lb[FW-1];
                if (&e) begin
                    man_raw = {1'b1, fr};
                    if (fr == '0) d.cls = d.sign ? C_NEGINF : C_POSINF;
                    else          d.cls = fr[MB-1] ? C_QNAN : C_SNAN;
                end else if (e == '0) begin
                    if (fr == '0) begin
                        d.cls = d.sign ? C_NEGZERO : C_POSZERO;
                    end else begin
                        man_raw = {1'b0, fr};
                        d.exp   = EXP_W'(1) - EXP_W'(BIAS);
                        d.cls   = d.sign ? C_NEGSUB : C_POSSUB;
                    end
                end else begin
                    man_raw = {1'b1, fr};
                    d.exp   = EXP_W'(e) - EXP_W'(BIAS);
                    d.cls   = d.sign ? C_NEGNORM : C_POSNORM;
                end
                d.man[MAN_W-1 -: MB+1] = man_raw;
            end

            assign dec[f] = d;
        end else begin : g_none
            assign dec[f] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (load) state_d = EMIT;
            EMIT: if (bus.out_ready && last) state_d = load ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == IDLE) || (last && bus.out_ready);
        bus.in_ready  = in_ready;
        bus.out_valid = 1'b0;
        bus.out_sign  = 1'b0;
        bus.out_exp   = '0;
        bus.out_man   = '0;
        bus.out_class = '0;
        bus.out_lane  = '0;
        bus.out_last  = 1'b0;
        bus.fmt_err   = fmt_err_q;
        if (state_q == EMIT) begin
            bus.out_valid = 1'b1;
            bus.out_sign  = dec[fmt_q].sign;
            bus.out_exp   = dec[fmt_q].exp;
            bus.out_man   = dec[fmt_q].man;
            bus.out_class = dec[fmt_q].cls;
            bus.out_lane  = lane_q;
            bus.out_last  = last;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q      <= '0;
            fmt_q       <= '0;
            lane_q      <= '0;
            last_lane_q <= '0;
            fmt_err_q   <= 1'b0;
        end else begin
            fmt_err_q <= accept & ~FMT_SUP[bus.in_fmt];
            if (load) begin
                word_q      <= bus.in_word;
                fmt_q       <= bus.in_fmt;
                lane_q      <= '0;
                last_lane_q <= LAST_LANES[bus.in_fmt*LANE_W +: LANE_W];
            end else if (state_q == EMIT && bus.out_ready && !last) begin
                lane_q <= lane_q + 1'b1;
            end
        end
    end
endmodule
